// File: rtl/mem_pkg.sv
// Shared encodings and data-formatting helpers for the MEM stage.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Byte-lane write enables for a store; size 11 behaves as a word.
  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << addr;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across all lanes; the byte enables
  // select which copy actually lands in the array.
  function automatic logic [31:0] store_lanes(input logic [31:0] data,
                                              input logic [1:0]  size);
    logic [31:0] w;
    case (size)
      SZ_HALF: w = {2{data[15:0]}};
      SZ_BYTE: w = {4{data[7:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  // Extract the addressed byte/halfword from a little-endian word and extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addr,
                                              input logic        sgn);
    logic [31:0] sh;
    logic [31:0] res;
    case (size)
      SZ_HALF: begin
        sh  = word >> {addr[1], 4'b0000};
        res = {{16{sgn & sh[15]}}, sh[15:0]};
      end
      SZ_BYTE: begin
        sh  = word >> {addr, 3'b000};
        res = {{24{sgn & sh[7]}}, sh[7:0]};
      end
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Synchronous single-port data RAM: byte-write enables, registered read.
module data_mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Byte-lane writes; contents are deliberately not cleared by reset.
  always_ff @(posedge Clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read port, cleared by reset so load data starts at zero.
  always_ff @(posedge Clk) begin
    if (Reset)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: fixed-latency data memory access, load formatting,
// misalignment suppression and control passthrough to MEM_WB.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        movIn,
  input  logic        jumpIn,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] PCAddressIn,
  output logic        RegWriteOut,
  output logic        MemToRegOut,
  output logic        movOut,
  output logic        jumpOut,
  output logic [4:0]  WriteRegisterOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] PCAddressOut,
  output logic [31:0] MemReadData,
  output logic        MemStall,
  output logic        MisalignFault
);

  mem_state_e  state;
  logic [3:0]  cnt;
  logic        req;
  logic        mis;
  logic        fire;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata_q;

  // Request decode and alignment check; a combined read+write is a store.
  always_comb begin
    req = MemRead | MemWrite;
    case (MemSize)
      SZ_HALF: mis = req & ALUResult[0];
      SZ_BYTE: mis = 1'b0;
      default: mis = req & (ALUResult[1:0] != 2'b00);
    endcase
  end

  // The array is touched only on the final BUSY edge, never under reset.
  always_comb begin
    fire = (state == ST_BUSY) && (cnt == '0) && !Reset;
    we   = (fire && MemWrite) ? byte_enable(MemSize, ALUResult[1:0]) : '0;
    re   = fire && !MemWrite;
  end

  data_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .Clk  (Clk),
    .Reset(Reset),
    .we   (we),
    .re   (re),
    .addr (ALUResult[ADDR_W+1:2]),
    .wdata(store_lanes(WriteData, MemSize)),
    .rdata(rdata_q)
  );

  // Access sequencer: IDLE -> BUSY (LATENCY wait cycles + access) -> DONE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !mis) begin
            cnt   <= 4'(LATENCY);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          else           state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall, fault and load-data outputs decoded from the current state.
  always_comb begin
    MemStall      = 1'b0;
    MisalignFault = 1'b0;
    MemReadData   = '0;
    if (!Reset) begin
      case (state)
        ST_IDLE: begin
          MemStall      = req & ~mis;
          MisalignFault = mis;
        end
        ST_BUSY: MemStall = 1'b1;
        ST_DONE: begin
          if (MemRead && !MemWrite)
            MemReadData = load_extend(rdata_q, MemSize, ALUResult[1:0], MemSigned);
        end
        default: ;
      endcase
    end
  end

  // Control passthrough to MEM_WB; a faulting access must not write back.
  always_comb begin
    RegWriteOut      = RegWrite & ~Reset & ~MisalignFault;
    jumpOut          = jumpIn & ~Reset;
    MemToRegOut      = MemToReg;
    movOut           = movIn;
    WriteRegisterOut = WriteRegister;
    ALUResultOut     = ALUResult;
    PCAddressOut     = PCAddressIn;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: two instances (LATENCY 2 and 0)
// compared against a byte-addressed reference memory model.
module tb_mem_access_stage;

  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        mrd [2];
  logic        mwr [2];
  logic [1:0]  msz [2];
  logic        msg [2];
  logic [31:0] alu [2];
  logic [31:0] wd  [2];
  logic        rw  [2];
  logic        m2r [2];
  logic        mov [2];
  logic        jin [2];
  logic [4:0]  wr  [2];
  logic [31:0] pc  [2];

  logic        rwo   [2];
  logic        m2ro  [2];
  logic        movo  [2];
  logic        jo    [2];
  logic [4:0]  wro   [2];
  logic [31:0] aluo  [2];
  logic [31:0] pco   [2];
  logic [31:0] rdd   [2];
  logic        stall [2];
  logic        fault [2];

  mem_access_stage #(.ADDR_W(10), .LATENCY(LAT0)) u_dut0 (
    .Clk(clk), .Reset(rst[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .MemSize(msz[0]), .MemSigned(msg[0]), .ALUResult(alu[0]), .WriteData(wd[0]),
    .RegWrite(rw[0]), .MemToReg(m2r[0]), .movIn(mov[0]), .jumpIn(jin[0]),
    .WriteRegister(wr[0]), .PCAddressIn(pc[0]),
    .RegWriteOut(rwo[0]), .MemToRegOut(m2ro[0]), .movOut(movo[0]), .jumpOut(jo[0]),
    .WriteRegisterOut(wro[0]), .ALUResultOut(aluo[0]), .PCAddressOut(pco[0]),
    .MemReadData(rdd[0]), .MemStall(stall[0]), .MisalignFault(fault[0])
  );

  mem_access_stage #(.ADDR_W(10), .LATENCY(LAT1)) u_dut1 (
    .Clk(clk), .Reset(rst[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .MemSize(msz[1]), .MemSigned(msg[1]), .ALUResult(alu[1]), .WriteData(wd[1]),
    .RegWrite(rw[1]), .MemToReg(m2r[1]), .movIn(mov[1]), .jumpIn(jin[1]),
    .WriteRegister(wr[1]), .PCAddressIn(pc[1]),
    .RegWriteOut(rwo[1]), .MemToRegOut(m2ro[1]), .movOut(movo[1]), .jumpOut(jo[1]),
    .WriteRegisterOut(wro[1]), .ALUResultOut(aluo[1]), .PCAddressOut(pco[1]),
    .MemReadData(rdd[1]), .MemStall(stall[1]), .MisalignFault(fault[1])
  );

  // Reference memory: 4096 bytes per instance, byte address = addr mod 4096.
  logic [7:0] mdl [2][4096];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lat(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int d, input logic [31:0] a,
                                           input logic [1:0] sz, input bit sg);
    int n = nbytes(sz);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++)
      v = v | (32'(mdl[d][(a + k) % 4096]) << (8 * k));
    if (sg && n == 1 && v[7])  v = v - 32'h100;
    if (sg && n == 2 && v[15]) v = v - 32'h10000;
    return v;
  endfunction

  task automatic ref_store(input int d, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] data);
    int n = nbytes(sz);
    for (int k = 0; k < n; k++)
      mdl[d][(a + k) % 4096] = 8'(data >> (8 * k));
  endtask

  task automatic idle_inputs(input int d);
    mrd[d] = 0; mwr[d] = 0; msz[d] = 0; msg[d] = 0; alu[d] = '0; wd[d] = '0;
    rw[d] = 0; m2r[d] = 0; mov[d] = 0; jin[d] = 0; wr[d] = '0; pc[d] = '0;
  endtask

  // One instruction through the stage; returns the load data seen in DONE.
  task automatic run_op(input int d, input bit rd, input bit wrt, input logic [1:0] sz,
                        input bit sg, input logic [31:0] a, input logic [31:0] data,
                        output logic [31:0] obs);
    logic        p_rw, p_m2r, p_mov, p_j;
    logic [4:0]  p_wr;
    logic [31:0] p_pc, exp_rd;
    bit          req, mis;
    int          n;
    p_rw  = 1'($urandom_range(0, 1));
    p_m2r = 1'($urandom_range(0, 1));
    p_mov = 1'($urandom_range(0, 1));
    p_j   = 1'($urandom_range(0, 1));
    p_wr  = 5'($urandom);
    p_pc  = $urandom;
    req   = rd | wrt;
    mis   = req && misaligned(a, sz);
    obs   = '0;
    @(negedge clk);
    mrd[d] = rd; mwr[d] = wrt; msz[d] = sz; msg[d] = sg; alu[d] = a; wd[d] = data;
    rw[d] = p_rw; m2r[d] = p_m2r; mov[d] = p_mov; jin[d] = p_j; wr[d] = p_wr; pc[d] = p_pc;
    #1;
    check("alu_pass", aluo[d], a);
    check("pc_pass", pco[d], p_pc);
    check("wreg_pass", 32'(wro[d]), 32'(p_wr));
    check("ctl_pass", {29'd0, m2ro[d], movo[d], jo[d]}, {29'd0, p_m2r, p_mov, p_j});
    check("idle_rdata", rdd[d], '0);
    check("fault", 32'(fault[d]), 32'(mis));
    check("regwrite", 32'(rwo[d]), 32'(p_rw & !mis));
    check("stall_first", 32'(stall[d]), 32'(req & !mis));
    if (mis) begin
      @(negedge clk);
      idle_inputs(d);
      #1;
      check("fault_1cyc", 32'(fault[d]), 32'd0);
    end else if (req) begin
      exp_rd = wrt ? 32'd0 : ref_load(d, a, sz, sg);
      n = 1;
      while (stall[d] && n < 40) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("cycles", 32'(n), 32'(lat(d) + 3));
      check("done_rdata", rdd[d], exp_rd);
      check("done_regwrite", 32'(rwo[d]), 32'(p_rw));
      obs = rdd[d];
      if (wrt) ref_store(d, a, sz, data);
    end
  endtask

  logic [31:0] obs;

  initial begin
    // Reset with requests pending: everything must stay quiet.
    for (int d = 0; d < 2; d++) idle_inputs(d);
    rst[0] = 1; rst[1] = 1;
    mrd[0] = 1; alu[0] = 32'h12; rw[0] = 1; jin[0] = 1;
    mwr[1] = 1; alu[1] = 32'h10; rw[1] = 1; jin[1] = 1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_stall", 32'(stall[d]), 32'd0);
      check("rst_fault", 32'(fault[d]), 32'd0);
      check("rst_rdata", rdd[d], '0);
      check("rst_rw_j", {30'd0, rwo[d], jo[d]}, 32'd0);
    end
    @(negedge clk);
    rst[0] = 0; rst[1] = 0;
    idle_inputs(0); idle_inputs(1);
    #1;
    check("post_rst_stall0", 32'(stall[0]), 32'd0);
    check("post_rst_stall1", 32'(stall[1]), 32'd0);

    // Directed sequence on the LATENCY=2 instance.
    run_op(0, 0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, obs);
    run_op(0, 1, 0, 2'b00, 0, 32'h10, '0, obs);
    check("lw_const", obs, 32'hDEADBEEF);
    run_op(0, 1, 0, 2'b10, 1, 32'h13, '0, obs);
    check("lb_const", obs, 32'hFFFFFFDE);
    run_op(0, 1, 0, 2'b10, 0, 32'h11, '0, obs);
    check("lbu_const", obs, 32'h000000BE);
    run_op(0, 1, 0, 2'b01, 1, 32'h12, '0, obs);
    check("lh_const", obs, 32'hFFFFDEAD);
    run_op(0, 0, 1, 2'b10, 0, 32'h11, 32'h00000055, obs);
    run_op(0, 1, 0, 2'b00, 0, 32'h10, '0, obs);
    check("sb_merge", obs, 32'hDEAD55EF);
    run_op(0, 1, 0, 2'b00, 0, 32'h12, '0, obs);
    run_op(0, 0, 1, 2'b01, 0, 32'h13, 32'h0000AAAA, obs);
    run_op(0, 1, 0, 2'b00, 0, 32'h10, '0, obs);
    check("mis_untouched", obs, 32'hDEAD55EF);

    // Reset during BUSY (cnt=1) aborts the store.
    run_op(0, 0, 1, 2'b00, 0, 32'h20, 32'hCAFEF00D, obs);
    @(negedge clk);
    mwr[0] = 1; msz[0] = 0; alu[0] = 32'h20; wd[0] = 32'h12345678; jin[0] = 1; rw[0] = 1;
    #1;
    check("abort_stall_idle", 32'(stall[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst[0] = 1;
    #1;
    check("abort_rst_stall", 32'(stall[0]), 32'd0);
    check("abort_rst_jump", 32'(jo[0]), 32'd0);
    @(negedge clk);
    rst[0] = 0;
    idle_inputs(0);
    #1;
    check("abort_idle_stall", 32'(stall[0]), 32'd0);
    run_op(0, 1, 0, 2'b00, 0, 32'h20, '0, obs);
    check("abort_prior", obs, 32'hCAFEF00D);

    // Non-memory instruction: same-cycle passthrough.
    @(negedge clk);
    idle_inputs(0);
    rw[0] = 1; alu[0] = 32'h7; jin[0] = 1;
    #1;
    check("nm_stall", 32'(stall[0]), 32'd0);
    check("nm_rw_j", {30'd0, rwo[0], jo[0]}, 32'd3);
    check("nm_alu", aluo[0], 32'h7);

    // LATENCY=0 instance: directed lw then randomized traffic on both.
    run_op(1, 0, 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, obs);
    run_op(1, 1, 0, 2'b00, 0, 32'h10, '0, obs);
    check("lat0_lw", obs, 32'hDEADBEEF);
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++)
        run_op(d, 0, 1, 2'b00, 0, 32'(w * 4), $urandom, obs);
      for (int i = 0; i < 60; i++) begin
        int unsigned kind;
        logic [1:0]  sz;
        logic [31:0] a;
        bit          rd, wrt;
        kind = $urandom_range(0, 9);
        sz   = 2'($urandom_range(0, 3));
        a    = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) < 7) a = a & ~32'(nbytes(sz) - 1);
        if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFFF000);
        rd  = (kind >= 1 && kind <= 5) || kind == 9;
        wrt = kind >= 6;
        run_op(d, rd, wrt, sz, 1'($urandom_range(0, 1)), a, $urandom, obs);
      end
      @(negedge clk);
      idle_inputs(d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
